// File: rtl/shift_pkg.sv
// +--------------------------------------------------------------------+
// | shift_pkg: shared FSM encoding, default width and len resolution.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package shift_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // A len of zero, or one larger than the register, means a full-width burst.
   function automatic int eff_len(input int len_val, input int width);
      if (len_val == 0 || len_val > width)
         return width;
      else
         return len_val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_reg.sv
// +--------------------------------------------------------------------+
// | shift_reg: parallel-load, MSB-first left shifter with zero fill.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module shift_reg
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);

   logic [WIDTH-1:0] sreg;

   always_ff @(posedge clk) begin
      if (rst)
         sreg <= '0;
      else if (load)
         sreg <= din;
      else if (en)
         sreg <= {sreg[WIDTH-2:0], 1'b0};
   end

   assign msb = sreg[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/shift_ctrl.sv
// +--------------------------------------------------------------------+
// | shift_ctrl: burst serialiser FSM with hold stall and done pulse.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module shift_ctrl
   import shift_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int LENW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic [LENW-1:0]  len,
   input  logic             hold,
   output logic             q,
   output logic             q_valid,
   output logic             busy,
   output logic             done
);

   // One extra bit so a full 2**LENW count never wraps.
   localparam int CNTW = LENW + 1;

   state_t            state;
   logic [CNTW-1:0]   cnt;
   logic              load;
   logic              shift_en;
   logic              msb;

   assign load     = (state == ST_IDLE) && start;
   assign shift_en = (state == ST_SHIFT) && !hold && (cnt != '0);

   shift_reg #(
      .WIDTH (WIDTH)
   ) u_shift_reg (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .en   (shift_en),
      .din  (din),
      .msb  (msb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         q       <= 1'b0;
         q_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               q       <= 1'b0;
               q_valid <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               if (start) begin
                  cnt   <= CNTW'(eff_len(int'(len), WIDTH));
                  busy  <= 1'b1;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               // A held edge only drops q_valid, so no bit is ever shown valid twice.
               if (hold) begin
                  q_valid <= 1'b0;
               end else if (cnt != '0) begin
                  q       <= msb;
                  q_valid <= 1'b1;
                  cnt     <= cnt - 1'b1;
               end else begin
                  q       <= 1'b0;
                  q_valid <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               q       <= 1'b0;
               q_valid <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               q       <= 1'b0;
               q_valid <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
